txs_burst_writer: RTL and testbench

- Downstream stage of the camera pixel path. Accepts 128-bit packed pixel words as a valid/ready stream.
- Buffers the words into fixed-length bursts and drives the PCIe TXS Avalon-MM write master (address, write, writedata, burstcount, waitrequest) into a host ring buffer.
- Signals frame completion to the IRQ/register logic.
- Sits between the pixel packer inside top and the platform TXS port.

---
 rtl/txs_pkg.sv | 15 +
 rtl/sync_fifo.sv | 51 +++++
 rtl/txs_burst_writer.sv | 144 ++++++++++++++
 tb/tb_txs_burst_writer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/txs_pkg.sv
// Shared types and helpers for the TXS burst writer.
package txs_pkg;

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  localparam int BEAT_BYTES = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and synchronous flush.
module sync_fifo
  import txs_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic          c,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge c) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/txs_burst_writer.sv
// Packs the pixel word stream into fixed-length Avalon-MM write bursts
// targeting a host ring buffer, and reports frame completion.
module txs_burst_writer
  import txs_pkg::*;
#(
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 22,
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              c,
  input  logic              rst,
  input  logic              enable,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [15:0]       cfg_bursts,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_eof,
  output logic [ADDR_W-1:0] txs_address,
  output logic              txs_write,
  output logic [DATA_W-1:0] txs_writedata,
  output logic [5:0]        txs_burstcount,
  input  logic              txs_waitrequest,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic              busy
);

  localparam int BB_LOG = clog2(BURST_LEN * BEAT_BYTES);
  localparam int CNT_W  = clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]  BL_C    = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] AMASK   = ~ADDR_W'(BURST_LEN * BEAT_BYTES - 1);

  state_t            state, state_d;
  logic [15:0]       burst_idx, last_idx;
  logic [5:0]        rem, len_d;
  logic              eof_held, eof_held_d, eof_seen;
  logic [DATA_W:0]   head;
  logic [CNT_W-1:0]  count, count_d;
  logic              full, empty;
  logic              push, pop, beat, last_beat, flush, start, burst_eof, in_ready_d;
  logic [ADDR_W-1:0] addr_d;

  sync_fifo #(.W(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .c     (c),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .wdata ({in_eof, in_data}),
    .pop   (pop),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign push      = in_valid & in_ready & ~full;
  assign beat      = txs_write & ~txs_waitrequest;
  assign pop       = beat;
  assign last_beat = beat & (rem == 6'd1);
  assign burst_eof = eof_seen | head[DATA_W];
  assign flush     = (state == IDLE) & ~enable;
  assign start     = (state == IDLE) & enable & ((count >= BL_C) | (eof_held & ~empty));
  assign len_d     = (eof_held && count < BL_C) ? 6'(count) : 6'(BURST_LEN);
  assign last_idx  = (cfg_bursts == 16'd0) ? 16'd0 : cfg_bursts - 16'd1;
  assign addr_d    = (cfg_base & AMASK) + ADDR_W'({burst_idx, {BB_LOG{1'b0}}});
  assign busy      = (state != IDLE);
  assign txs_writedata = txs_write ? head[DATA_W-1:0] : '0;

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = BURST;
      BURST:   if (last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // in_ready is registered, so it must look ahead at next-cycle occupancy and eof state
  always_comb begin
    eof_held_d = eof_held;
    if (flush || (state == DONE && eof_seen)) eof_held_d = 1'b0;
    else if (push && in_eof)                  eof_held_d = 1'b1;
    count_d    = flush ? '0 : count + CNT_W'(push) - CNT_W'(pop);
    in_ready_d = enable & (count_d != DEPTH_C) & ~eof_held_d;
  end

  always_ff @(posedge c or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      in_ready       <= 1'b0;
      eof_held       <= 1'b0;
      eof_seen       <= 1'b0;
      burst_idx      <= '0;
      rem            <= '0;
      txs_write      <= 1'b0;
      txs_address    <= '0;
      txs_burstcount <= '0;
      frame_done     <= 1'b0;
      frame_count    <= '0;
    end else begin
      in_ready   <= in_ready_d;
      eof_held   <= eof_held_d;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (flush) burst_idx <= '0;
          if (start) begin
            txs_write      <= 1'b1;
            txs_address    <= addr_d;
            txs_burstcount <= len_d;
            rem            <= len_d;
            eof_seen       <= 1'b0;
          end
        end
        BURST: begin
          if (beat) begin
            rem      <= rem - 6'd1;
            eof_seen <= burst_eof;
          end
          if (last_beat) begin
            txs_write   <= 1'b0;
            frame_done  <= burst_eof;
            frame_count <= frame_count + 16'(burst_eof);
          end
        end
        DONE: begin
          if (eof_seen)                    burst_idx <= '0;
          else if (burst_idx >= last_idx)  burst_idx <= '0;
          else                             burst_idx <= burst_idx + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_txs_burst_writer.sv
// Directed bench for txs_burst_writer: bursts, partial frames, ring wrap,
// stalls, enable drop and asynchronous reset.
module tb_txs_burst_writer;

  logic         c = 1'b0;
  logic         rst, enable, in_valid, in_ready, in_eof;
  logic [21:0]  cfg_base, txs_address;
  logic [15:0]  cfg_bursts, frame_count;
  logic [127:0] in_data, txs_writedata;
  logic         txs_write, txs_waitrequest, frame_done, busy;
  logic [5:0]   txs_burstcount;

  int pass_cnt = 0;
  int total    = 0;
  int fd_cnt   = 0;
  logic [21:0]  q_a [$];
  logic [5:0]   q_bc[$];
  logic [127:0] q_d [$];

  always #5 c = ~c;

  txs_burst_writer dut (
    .c               (c),
    .rst             (rst),
    .enable          (enable),
    .cfg_base        (cfg_base),
    .cfg_bursts      (cfg_bursts),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .in_eof          (in_eof),
    .txs_address     (txs_address),
    .txs_write       (txs_write),
    .txs_writedata   (txs_writedata),
    .txs_burstcount  (txs_burstcount),
    .txs_waitrequest (txs_waitrequest),
    .frame_done      (frame_done),
    .frame_count     (frame_count),
    .busy            (busy)
  );

  // Accepted beats and frame_done pulses, sampled mid-cycle
  always @(negedge c) begin
    if (!rst) begin
      if (txs_write && !txs_waitrequest) begin
        q_a.push_back(txs_address);
        q_bc.push_back(txs_burstcount);
        q_d.push_back(txs_writedata);
      end
      if (frame_done) fd_cnt++;
    end
  end

  task automatic clear_q();
    q_a.delete();
    q_bc.delete();
    q_d.delete();
  endtask

  task automatic send(input int base, input int n, input bit eof_last);
    int k;
    @(posedge c); #1;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = 128'(base + i);
      in_eof   = eof_last && (i == n - 1);
      k = 0;
      do begin @(negedge c); k++; end while (!in_ready && k < 200);
      @(posedge c); #1;
    end
    in_valid = 1'b0;
    in_eof   = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int k;
    k = 0;
    while (q_d.size() < n && k < 300) begin
      @(negedge c); #1;
      k++;
    end
  endtask

  task automatic quiesce();
    @(posedge c); #1 enable = 1'b0;
    repeat (3) @(posedge c);
    #1 enable = 1'b1;
    repeat (2) @(posedge c);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge c);
    total++; if (txs_write !== 1'b0) $display("FAIL reset_write got=%b exp=0", txs_write); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
    total++; if (in_ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", in_ready); else pass_cnt++;
    total++; if (frame_count !== 16'd0) $display("FAIL reset_fcount got=%0d exp=0", frame_count); else pass_cnt++;
    total++; if (txs_address !== 22'd0) $display("FAIL reset_addr got=%h exp=0", txs_address); else pass_cnt++;
    @(posedge c); #1 rst = 1'b0; enable = 1'b1;
    @(negedge c);
    total++; if (in_ready !== 1'b0) $display("FAIL release_ready_early got=%b exp=0", in_ready); else pass_cnt++;
    @(negedge c);
    total++; if (in_ready !== 1'b1) $display("FAIL release_ready got=%b exp=1", in_ready); else pass_cnt++;
  endtask

  task automatic test_single_frame();
    logic [155:0] got, exp;
    int fd0;
    clear_q();
    fd0 = fd_cnt;
    send(0, 8, 1'b1);
    wait_beats(8);
    repeat (4) @(negedge c);
    total++; if (q_d.size() !== 8) $display("FAIL single_nbeats got=%0d exp=8", q_d.size()); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      exp = {22'h1000, 6'd8, 128'(i)};
      got = (i < q_d.size()) ? {q_a[i], q_bc[i], q_d[i]} : 'x;
      total++; if (got !== exp) $display("FAIL single_beat%0d got=%h exp=%h", i, got, exp); else pass_cnt++;
    end
    total++; if (fd_cnt - fd0 !== 1) $display("FAIL single_fdone got=%0d exp=1", fd_cnt - fd0); else pass_cnt++;
    total++; if (frame_count !== 16'd1) $display("FAIL single_fcount got=%0d exp=1", frame_count); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL single_busy got=%b exp=0", busy); else pass_cnt++;
  endtask

  task automatic test_partial_frame();
    logic [155:0] got, exp;
    int fd0;
    clear_q();
    fd0 = fd_cnt;
    send(100, 20, 1'b1);
    wait_beats(20);
    repeat (4) @(negedge c);
    total++; if (q_d.size() !== 20) $display("FAIL partial_nbeats got=%0d exp=20", q_d.size()); else pass_cnt++;
    for (int i = 0; i < 20; i++) begin
      exp = {22'h1000 + 22'((i / 8) * 128), (i < 16) ? 6'd8 : 6'd4, 128'(100 + i)};
      got = (i < q_d.size()) ? {q_a[i], q_bc[i], q_d[i]} : 'x;
      total++; if (got !== exp) $display("FAIL partial_beat%0d got=%h exp=%h", i, got, exp); else pass_cnt++;
    end
    total++; if (fd_cnt - fd0 !== 1) $display("FAIL partial_fdone got=%0d exp=1", fd_cnt - fd0); else pass_cnt++;
    total++; if (frame_count !== 16'd2) $display("FAIL partial_fcount got=%0d exp=2", frame_count); else pass_cnt++;
    clear_q();
    send(200, 8, 1'b1);
    wait_beats(8);
    repeat (4) @(negedge c);
    got = (q_d.size() > 0) ? {q_a[0], q_bc[0], q_d[0]} : 'x;
    exp = {22'h1000, 6'd8, 128'(200)};
    total++; if (got !== exp) $display("FAIL restart_beat0 got=%h exp=%h", got, exp); else pass_cnt++;
    total++; if (frame_count !== 16'd3) $display("FAIL restart_fcount got=%0d exp=3", frame_count); else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [155:0] got, exp;
    int fd0;
    clear_q();
    fd0 = fd_cnt;
    @(posedge c); #1 cfg_bursts = 16'd2;
    send(300, 40, 1'b0);
    wait_beats(40);
    repeat (4) @(negedge c);
    total++; if (q_d.size() !== 40) $display("FAIL wrap_nbeats got=%0d exp=40", q_d.size()); else pass_cnt++;
    for (int i = 0; i < 40; i += 8) begin
      exp = {22'h1000 + 22'(((i / 8) % 2) * 128), 6'd8, 128'(300 + i)};
      got = (i < q_d.size()) ? {q_a[i], q_bc[i], q_d[i]} : 'x;
      total++; if (got !== exp) $display("FAIL wrap_burst%0d got=%h exp=%h", i / 8, got, exp); else pass_cnt++;
    end
    got = (q_d.size() == 40) ? {q_a[39], q_bc[39], q_d[39]} : 'x;
    exp = {22'h1000, 6'd8, 128'(339)};
    total++; if (got !== exp) $display("FAIL wrap_last got=%h exp=%h", got, exp); else pass_cnt++;
    total++; if (fd_cnt - fd0 !== 0) $display("FAIL wrap_fdone got=%0d exp=0", fd_cnt - fd0); else pass_cnt++;
    total++; if (frame_count !== 16'd3) $display("FAIL wrap_fcount got=%0d exp=3", frame_count); else pass_cnt++;
    cfg_bursts = 16'd16;
  endtask

  task automatic test_waitrequest();
    logic [155:0] got, exp, prev;
    bit prev_st;
    int n_stall;
    quiesce();
    clear_q();
    txs_waitrequest = 1'b1;
    send(400, 8, 1'b0);
    prev_st = 1'b0;
    prev    = '0;
    n_stall = 0;
    for (int cyc = 0; cyc < 200 && q_d.size() < 8; cyc++) begin
      @(posedge c); #1 txs_waitrequest = (cyc < 2) ? 1'b1 : (cyc % 2 == 1);
      @(negedge c);
      got = {txs_address, txs_burstcount, txs_writedata};
      if (prev_st) begin
        n_stall++;
        total++; if (got !== prev) $display("FAIL stall_stable cyc%0d got=%h exp=%h", cyc, got, prev); else pass_cnt++;
      end
      prev_st = txs_write && txs_waitrequest;
      prev    = got;
      #1;
    end
    @(posedge c); #1 txs_waitrequest = 1'b0;
    repeat (6) @(negedge c);
    total++; if (!(n_stall >= 2)) $display("FAIL stall_seen got=%0d exp=>=2", n_stall); else pass_cnt++;
    total++; if (q_d.size() !== 8) $display("FAIL stall_nbeats got=%0d exp=8", q_d.size()); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      exp = {22'h1000, 6'd8, 128'(400 + i)};
      got = (i < q_d.size()) ? {q_a[i], q_bc[i], q_d[i]} : 'x;
      total++; if (got !== exp) $display("FAIL stall_beat%0d got=%h exp=%h", i, got, exp); else pass_cnt++;
    end
  endtask

  task automatic test_enable_drop();
    logic [155:0] got, exp;
    quiesce();
    clear_q();
    txs_waitrequest = 1'b1;
    send(500, 13, 1'b0);
    @(posedge c); #1 txs_waitrequest = 1'b0;
    wait_beats(3);
    @(posedge c); #1 enable = 1'b0;
    repeat (20) @(negedge c);
    total++; if (q_d.size() !== 8) $display("FAIL endrop_nbeats got=%0d exp=8", q_d.size()); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      exp = {22'h1000, 6'd8, 128'(500 + i)};
      got = (i < q_d.size()) ? {q_a[i], q_bc[i], q_d[i]} : 'x;
      total++; if (got !== exp) $display("FAIL endrop_beat%0d got=%h exp=%h", i, got, exp); else pass_cnt++;
    end
    total++; if (in_ready !== 1'b0) $display("FAIL endrop_ready got=%b exp=0", in_ready); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL endrop_busy got=%b exp=0", busy); else pass_cnt++;
    @(posedge c); #1 enable = 1'b1;
    clear_q();
    send(600, 8, 1'b0);
    wait_beats(8);
    repeat (4) @(negedge c);
    total++; if (q_d.size() !== 8) $display("FAIL reen_nbeats got=%0d exp=8", q_d.size()); else pass_cnt++;
    for (int i = 0; i < 8; i += 7) begin
      exp = {22'h1000, 6'd8, 128'(600 + i)};
      got = (i < q_d.size()) ? {q_a[i], q_bc[i], q_d[i]} : 'x;
      total++; if (got !== exp) $display("FAIL reen_beat%0d got=%h exp=%h", i, got, exp); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_burst();
    int k;
    txs_waitrequest = 1'b1;
    send(700, 8, 1'b0);
    k = 0;
    while (!txs_write && k < 50) begin @(negedge c); k++; end
    total++; if (txs_write !== 1'b1) $display("FAIL rstmid_started got=%b exp=1", txs_write); else pass_cnt++;
    @(negedge c); #2 rst = 1'b1;
    #1;
    total++; if (txs_write !== 1'b0) $display("FAIL rstmid_write got=%b exp=0", txs_write); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", busy); else pass_cnt++;
    total++; if (frame_count !== 16'd0) $display("FAIL rstmid_fcount got=%0d exp=0", frame_count); else pass_cnt++;
    total++; if (in_ready !== 1'b0) $display("FAIL rstmid_ready got=%b exp=0", in_ready); else pass_cnt++;
    clear_q();
    @(posedge c); #1 rst = 1'b0; txs_waitrequest = 1'b0;
    @(negedge c);
    total++; if (in_ready !== 1'b0) $display("FAIL rstrel_ready_early got=%b exp=0", in_ready); else pass_cnt++;
    @(negedge c);
    total++; if (in_ready !== 1'b1) $display("FAIL rstrel_ready got=%b exp=1", in_ready); else pass_cnt++;
    repeat (4) @(negedge c);
    total++; if (q_d.size() !== 0) $display("FAIL rstrel_nbeats got=%0d exp=0", q_d.size()); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL rstrel_busy got=%b exp=0", busy); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; in_valid = 1'b0; in_eof = 1'b0; in_data = '0;
    cfg_base = 22'h1000; cfg_bursts = 16'd16; txs_waitrequest = 1'b0;
    test_reset();
    test_single_frame();
    test_partial_frame();
    test_wrap();
    test_waitrequest();
    test_enable_drop();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
